// File: rtl/ram_param.sv
// Single-port parameterised RAM with registered read, selectable read/write collision
// behaviour, and a one-word-per-cycle clear sweep started by reset or by a clr pulse.
module ram_param #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 3,
   parameter bit WRITE_FIRST = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic              clr,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;
   logic              rd_go;

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      unique case (state)
         IDLE: begin
            if (clr) begin
               state_nxt = CLEAR;
               ptr_nxt   = '0;
            end
         end
         CLEAR: begin
            // Stop on the terminal address rather than wrapping into a second sweep
            if (ptr == ADDR_W'(DEPTH - 1)) state_nxt = IDLE;
            else                           ptr_nxt   = ptr + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   assign busy = (state == CLEAR);

   // clr wins over wr_en/rd_en in IDLE; the sweep owns the write port while busy
   always_comb begin
      mem_we = 1'b0;
      mem_wa = addr;
      mem_wd = data_in;
      rd_go  = 1'b0;
      if (!rst) begin
         if (state == CLEAR) begin
            mem_we = 1'b1;
            mem_wa = ptr;
            mem_wd = '0;
         end else if (!clr) begin
            mem_we = wr_en;
            rd_go  = rd_en;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_go;
         if (rd_go) data_out <= (WRITE_FIRST && wr_en) ? data_in : mem[addr];
      end
   end
endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: two instances (read-first and write-first) share stimulus
// and are checked against a table of hand-computed expected outputs.
module tb_ram_param;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, clr, wr_en, rd_en;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] dout0, dout1;
   logic              vld0, vld1, busy0, busy1;

   ram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr_en(wr_en),
      .rd_en(rd_en), .clr(clr), .data_out(dout0), .rd_valid(vld0), .busy(busy0));

   ram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRITE_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr_en(wr_en),
      .rd_en(rd_en), .clr(clr), .data_out(dout1), .rd_valid(vld1), .busy(busy1));

   typedef struct {
      logic       rst, clr, wr, rd;
      logic [2:0] addr;
      logic [7:0] din, d0, d1;
      logic       vld, busy;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void add(input logic r, input logic c, input logic w, input logic rd,
                               input logic [2:0] a, input logic [7:0] din,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic vld, input logic bsy);
      vec_t v;
      v.rst = r; v.clr = c; v.wr = w; v.rd = rd; v.addr = a; v.din = din;
      v.d0 = d0; v.d1 = d1; v.vld = vld; v.busy = bsy;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int         cnt;
      logic [7:0] held;

      rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; data_in = '0;

      // reset then idle sweep, then every word reads zero
      add(1,0,0,0,0,8'h00, 8'h00,8'h00,0,1);
      add(1,0,0,0,0,8'h00, 8'h00,8'h00,0,1);
      for (int i = 0; i < 7; i++) add(0,0,0,0,0,8'h00, 8'h00,8'h00,0,1);
      add(0,0,0,0,0,8'h00, 8'h00,8'h00,0,0);
      for (int a = 0; a < 8; a++) add(0,0,0,1,3'(a),8'h00, 8'h00,8'h00,1,0);

      // write, read back, then hold
      add(0,0,1,0,3,8'hA5, 8'h00,8'h00,0,0);
      add(0,0,0,1,3,8'h00, 8'hA5,8'hA5,1,0);
      add(0,0,0,0,3,8'h00, 8'hA5,8'hA5,0,0);

      // collision: read-first returns old, write-first returns new; memory gets new
      add(0,0,1,0,5,8'h11, 8'hA5,8'hA5,0,0);
      add(0,0,1,1,5,8'h22, 8'h11,8'h22,1,0);
      add(0,0,0,1,5,8'h00, 8'h22,8'h22,1,0);

      // fill with FF, clr with a write of 77 and a read, accesses during sweep ignored
      for (int a = 0; a < 8; a++) add(0,0,1,0,3'(a),8'hFF, 8'h22,8'h22,0,0);
      add(0,1,1,1,2,8'h77, 8'h22,8'h22,0,1);
      for (int i = 0; i < 7; i++) add(0,1,1,1,3'(i),8'h33, 8'h22,8'h22,0,1);
      add(0,1,1,1,7,8'h33, 8'h22,8'h22,0,0);
      for (int a = 0; a < 8; a++) add(0,0,0,1,3'(a),8'h00, 8'h00,8'h00,1,0);

      // reset on the 4th cycle of a sweep restarts it from address 0
      add(0,0,1,0,0,8'h5A, 8'h00,8'h00,0,0);
      add(0,0,1,0,7,8'h5A, 8'h00,8'h00,0,0);
      add(0,0,0,1,7,8'h00, 8'h5A,8'h5A,1,0);
      add(0,1,0,0,0,8'h00, 8'h5A,8'h5A,0,1);
      for (int i = 0; i < 3; i++) add(0,0,0,0,0,8'h00, 8'h5A,8'h5A,0,1);
      add(1,0,0,0,0,8'h00, 8'h00,8'h00,0,1);
      for (int i = 0; i < 7; i++) add(0,0,1,0,0,8'h99, 8'h00,8'h00,0,1);
      add(0,0,0,0,0,8'h00, 8'h00,8'h00,0,0);
      for (int a = 0; a < 8; a++) add(0,0,0,1,3'(a),8'h00, 8'h00,8'h00,1,0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; clr = vecs[i].clr; wr_en = vecs[i].wr; rd_en = vecs[i].rd;
         addr = vecs[i].addr; data_in = vecs[i].din;
         tick();
         chk("data_out_rf", i, 32'(dout0), 32'(vecs[i].d0));
         chk("data_out_wf", i, 32'(dout1), 32'(vecs[i].d1));
         chk("rd_valid_rf", i, 32'(vld0),  32'(vecs[i].vld));
         chk("rd_valid_wf", i, 32'(vld1),  32'(vecs[i].vld));
         chk("busy_rf",     i, 32'(busy0), 32'(vecs[i].busy));
         chk("busy_wf",     i, 32'(busy1), 32'(vecs[i].busy));
      end

      // hand sequence: write 0xC3, read it, then clr and measure busy length with a bound
      rst = 1'b0; clr = 1'b0; rd_en = 1'b0; wr_en = 1'b1; addr = 3'd4; data_in = 8'hC3;
      tick();
      wr_en = 1'b0; rd_en = 1'b1;
      tick();
      chk("seq_read", 0, 32'(dout0), 32'h0000_00C3);
      held = dout0;
      rd_en = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0; rd_en = 1'b1; wr_en = 1'b1; data_in = 8'h66;
      cnt = 0;
      while (busy0 && cnt < 20) begin
         chk("seq_vld_in_sweep", cnt, 32'(vld0), 32'h0);
         chk("seq_dout_hold", cnt, 32'(dout0), 32'(held));
         tick();
         cnt++;
      end
      chk("seq_busy_len", 0, 32'(cnt), 32'd8);
      rd_en = 1'b1; wr_en = 1'b0; addr = 3'd4;
      tick();
      chk("seq_cleared", 0, 32'(dout0), 32'h0);
      chk("seq_cleared_vld", 0, 32'(vld0), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits.
REQ-002 Parameter ADDR_W, default 3: address width; depth DEPTH = 2**ADDR_W, derived and not overridable.
REQ-003 Parameter WRITE_FIRST, default 0: same-address read/write collision mode (0 = read-first, 1 = write-first).
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high; starts a full memory clear sweep.
REQ-006 addr  input  ADDR_W  read/write address; every value is in range.
REQ-007 data_in  input  DATA_W  write data.
REQ-008 wr_en  input  1  write strobe, sampled each edge.
REQ-009 rd_en  input  1  read strobe, sampled each edge.
REQ-010 clr  input  1  single-cycle request to zero the whole memory.
REQ-011 data_out  output  DATA_W  registered read data.
REQ-012 rd_valid  output  1  high for one cycle when data_out holds a new read result.
REQ-013 busy  output  1  high while a clear sweep is in progress.

Function
REQ-014 Storage: DEPTH words of DATA_W bits; two states, IDLE and CLEAR, plus a clear pointer of ADDR_W bits.
REQ-015 In IDLE with wr_en=1 and clr=0: mem[addr] <= data_in at the edge.
REQ-016 In IDLE with rd_en=1 and clr=0: data_out <= mem[addr] and rd_valid <= 1 at the edge; read latency is exactly 1 cycle.
REQ-017 In IDLE with rd_en=0: rd_valid <= 0; data_out holds its previous value.
REQ-018 Collision (rd_en=1, wr_en=1, same address) with WRITE_FIRST=0: data_out gets the old contents.
REQ-019 Collision with WRITE_FIRST=1: data_out gets data_in.
REQ-020 In both collision modes the memory holds data_in after the edge.
REQ-021 In IDLE with clr=1: state <= CLEAR, pointer <= 0, busy <= 1, rd_valid <= 0.
REQ-022 clr has priority over wr_en and rd_en: in the clr cycle the write is dropped and no read is performed.
REQ-023 In CLEAR, each edge: mem[pointer] <= 0 and pointer increments by 1.
REQ-024 In CLEAR, the edge that clears mem[DEPTH-1] sets state <= IDLE and busy <= 0; busy is therefore high for exactly DEPTH cycles per sweep.
REQ-025 In CLEAR, wr_en, rd_en and clr are ignored, rd_valid = 0, and data_out holds.
REQ-026 The pointer stops at the terminal address and does not wrap into a second sweep.
REQ-027 The first cycle after busy falls is a normal IDLE cycle and accepts reads and writes.

Reset
REQ-028 While rst=1 at an edge: state <= CLEAR, pointer <= 0, busy <= 1, data_out <= 0, rd_valid <= 0; memory is not written in that cycle.
REQ-029 rst has priority over every other input in every state.
REQ-030 rst asserted mid-sweep restarts the sweep at address 0.
REQ-031 After rst deasserts, busy stays high for DEPTH cycles, after which all words read 0.
REQ-032 Reset is synchronous only; no state changes except on clk rising edges.

Verification (defaults DATA_W=8, ADDR_W=3)
REQ-033 Reset, then idle:
- Stimulus: rst high 2 cycles, then low.
- Response: busy high for exactly 8 cycles; data_out=0x00 and rd_valid=0 throughout.
- Then: reads of addresses 0..7 each return 0x00 with rd_valid=1 one cycle later.
REQ-034 Write then read:
- Stimulus: write 0xA5 to address 3; next cycle rd_en at address 3.
- Response: data_out=0xA5 and rd_valid=1 on the following cycle.
- Then: rd_en=0 gives rd_valid=0 with data_out held at 0xA5.
REQ-035 Collision:
- Stimulus: mem[5]=0x11; same-cycle wr_en and rd_en at address 5 with data_in=0x22.
- Response: data_out=0x11 when WRITE_FIRST=0; data_out=0x22 when WRITE_FIRST=1.
- Then: a later read of address 5 returns 0x22 in both modes.
REQ-036 Clear request:
- Stimulus: write 0xFF to all 8 addresses; pulse clr together with wr_en at address 2, data 0x77.
- Response: busy high for 8 cycles.
- Then: all addresses read 0x00, and 0x77 was never stored.
REQ-037 Access during sweep:
- Stimulus: rd_en, wr_en and clr driven while busy=1.
- Response: rd_valid stays 0 and data_out stays unchanged.
- Then: after the sweep, memory contents are all 0x00.
REQ-038 Reset mid-sweep:
- Stimulus: rst pulsed on the 4th cycle of a clr sweep.
- Response: busy stays high for 8 further cycles after rst deasserts.
- Then: all words read 0x00.
